// File: rtl/result_pipe_pkg.sv
// Shared types and constants for the M/W result pipeline.
package result_pipe_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } load_size_e;

  typedef struct packed {
    logic              valid;
    logic [4:0]        dest;
    logic [DATA_W-1:0] value;
    logic              is_load;
    load_size_e        size;
    logic              is_signed;
    logic [1:0]        addr_low;
    logic              done;
  } m_stage_t;

  typedef struct packed {
    logic              valid;
    logic [4:0]        dest;
    logic [DATA_W-1:0] value;
  } w_stage_t;

endpackage

// File: rtl/result_pipe_load_align.sv
// Combinational load-lane select plus sign/zero extension.
module load_align
  import result_pipe_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  load_size_e        size,
  input  logic              is_signed,
  input  logic [1:0]        addr_low,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the byte/half lane addressed by the low address bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    byte_lane = word[7:0];
    case (addr_low)
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      2'd3:    byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = addr_low[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane; word loads pass straight through.
  always_comb begin
    value = word;
    case (size)
      LS_BYTE: value = {{24{is_signed & byte_lane[7]}}, byte_lane};
      LS_HALF: value = {{16{is_signed & half_lane[15]}}, half_lane};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/result_pipe.sv
// M and W result stages: registers ALU results, holds loads in M until the
// data memory responds, drives two forwarding sources and the RF write port.
// Optional feature: define RESULT_PIPE_PERF_EN to enable the load-wait
// cycle counter; otherwise load_wait_cycles is tied to zero.
module result_pipe
  import result_pipe_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [4:0]        ex_dest,
  input  logic [DATA_W-1:0] ex_value,
  input  logic              ex_is_load,
  input  logic [1:0]        ex_load_size,
  input  logic              ex_load_signed,
  input  logic [1:0]        ex_addr_low,
  output logic              ex_ready,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  output logic              src1_valid,
  output logic [4:0]        src1_reg,
  output logic [DATA_W-1:0] src1_value,
  output logic              src2_valid,
  output logic [4:0]        src2_reg,
  output logic [DATA_W-1:0] src2_value,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [PERF_W-1:0] load_wait_cycles
);

  m_stage_t          m_q;
  w_stage_t          w_q;
  logic              discard_q;
  logic              load_resp;
  logic              m_done_now;
  logic              ex_take;
  logic              advance;
  logic              flush_set;
  logic [DATA_W-1:0] aligned;

  // A response belongs to the M load only when no flushed load is still owed one.
  assign load_resp  = m_q.valid & m_q.is_load & mem_data_valid & ~discard_q;
  assign m_done_now = m_q.valid & (m_q.done | load_resp);
  assign ex_ready   = ~m_q.valid | m_done_now;
  assign ex_take    = ex_valid & ex_ready & ~flush;
  assign advance    = m_done_now & ~flush;
  // Flushing a load that is still waiting leaves one response to swallow.
  assign flush_set  = flush & m_q.valid & m_q.is_load & ~m_q.done & ~load_resp;

  load_align u_load_align (
    .word      (mem_data),
    .size      (m_q.size),
    .is_signed (m_q.is_signed),
    .addr_low  (m_q.addr_low),
    .value     (aligned)
  );

  // M stage: capture an EX transfer, otherwise empty out once done or flushed.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) begin
      m_q <= '0;
    end else if (ex_take) begin
      m_q <= '{valid:     1'b1,
               dest:      ex_dest,
               value:     ex_is_load ? '0 : ex_value,
               is_load:   ex_is_load,
               size:      load_size_e'(ex_load_size),
               is_signed: ex_load_signed,
               addr_low:  ex_addr_low,
               done:      ~ex_is_load};
    end else if (m_done_now | flush) begin
      m_q <= '0;
    end
  end

  // W stage: take the finished M entry, else go empty (dest 0, valid 0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_q <= '0;
    end else if (advance) begin
      w_q <= '{valid: 1'b1,
               dest:  m_q.dest,
               value: m_q.is_load ? aligned : m_q.value};
    end else begin
      w_q <= '0;
    end
  end

  // Discard flag: set by flushing a waiting load, cleared by the next response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_q <= 1'b0;
    end else begin
      discard_q <= flush_set | (discard_q & ~mem_data_valid);
    end
  end

  // Empty stages hold all-zero contents, so outputs need no extra gating.
  assign src1_valid = m_q.valid & m_q.done;
  assign src1_reg   = m_q.dest;
  assign src1_value = m_q.value;
  assign src2_valid = w_q.valid;
  assign src2_reg   = w_q.dest;
  assign src2_value = w_q.value;
  assign wb_we      = w_q.valid & (w_q.dest != 5'd0);
  assign wb_addr    = w_q.dest;
  assign wb_data    = w_q.value;

`ifdef RESULT_PIPE_PERF_EN
  logic [PERF_W-1:0] perf_q;

  // Count cycles M holds an unfinished load, saturating at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else if (m_q.valid & m_q.is_load & ~m_q.done & ~(&perf_q)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign load_wait_cycles = perf_q;
`else
  assign load_wait_cycles = '0;
`endif

endmodule

// File: doc/result_pipe.md
# result_pipe

Result pipeline for the M and W stages of the integer core. It registers execute-stage results and holds loads in M until the data memory responds. Loaded data is aligned and sign- or zero-extended. The block drives the two forwarding sources consumed by the forwarding controller (M = priority-1 source, W = priority-2 source) and the register-file write port. It back-pressures execute while a load is outstanding.

## Interface
Parameters:
- PERF_W, 32, width of the load-wait cycle counter.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute offers an instruction this cycle.
- ex_dest  in  5  destination register (0 = no writeback).
- ex_value  in  32  ALU result (ignored for loads).
- ex_is_load  in  1  value comes from data memory.
- ex_load_size  in  2  0 = byte, 1 = half, 2 = word.
- ex_load_signed  in  1  sign-extend byte/half.
- ex_addr_low  in  2  address bits [1:0] for lane select.
- ex_ready  out  1  M can accept this cycle.
- mem_data_valid  in  1  load response strobe.
- mem_data  in  32  load response word.
- flush  in  1  kill the M-stage entry.
- src1_valid, src1_reg, src1_value  out  1/5/32  M-stage forwarding source.
- src2_valid, src2_reg, src2_value  out  1/5/32  W-stage forwarding source.
- wb_we, wb_addr, wb_data  out  1/5/32  register-file write.
- load_wait_cycles  out  PERF_W  stall counter (see Configuration).

## Operation
- **Stages.** M holds {valid, dest, value, is_load, size, signed, addr_low, done}; W holds {valid, dest, value}.
- **Empty stages.** An empty stage drives reg = 0 and valid = 0, so it never matches a nonzero request.
- **M done.**
  - Non-load: done on entry.
  - Load: done in the cycle `mem_data_valid` = 1 while not discarding.
- **Accept.** `ex_ready` = !m_valid | m_done_now, where m_done_now includes a same-cycle `mem_data_valid`. An EX transfer occurs when ex_valid & ex_ready & !flush.
- **Advance.** When M is done (or becomes done this cycle), M moves to W at the clock edge. The value is the aligned load data or the ALU value. Otherwise W is loaded with invalid.
- **W retirement.** W retires every cycle: wb_we = w_valid & (w_dest != 0).
- **Forwarding outputs.**
  - src1_valid = m_valid & m_done_registered.
  - src2_valid = w_valid.
  - A pending load shows src1_reg = dest with src1_valid = 0, so the forwarding controller stalls.
- **Load alignment.** Byte selects lane addr_low and half selects lane addr_low[1]. The selected lane is extended per `ex_load_signed`. For a word load addr_low is ignored.
- **Flush.**
  - M is invalidated; W is unaffected.
  - If the flushed M entry is a load still waiting, set `discard`. The next `mem_data_valid` is consumed silently, then `discard` clears.
  - While `discard` = 1, a new load may enter M. Responses are in order, so the first response is always dropped.
- **Simultaneous flush and EX offer.** The offer is not accepted; ex_ready is still reported from state.
- **Simultaneous flush and mem_data_valid for the M load.** The response counts as consumed; `discard` is not set.

## Timing
- **Reset.** All valid bits, `discard`, regs, values and `load_wait_cycles` = 0. `ex_ready` = 1; wb_we = 0.
- **ALU result.** Accepted at edge t. Visible on src1 during cycle t+1, on src2/wb in t+2.
- **Load.** Accepted at edge t. src1_valid = 0 from t+1 until the response cycle c (c ≥ t+1). The data appears on src2/wb in c+1 and never on src1.
- **Throughput.** Back-to-back non-loads sustain one per cycle.
- **Mid-operation reset.** Asserting resetn low clears state immediately, including `discard`. Any in-flight memory response after reset must be suppressed by the memory side.

## Configuration
- **`RESULT_PIPE_PERF_EN` defined.** `load_wait_cycles` increments (saturating at all-ones) on every cycle m_valid & is_load & !done, including cycles with `discard` active and M occupied.
- **Not defined.** The counter logic is absent and `load_wait_cycles` is tied to 0.

## Structure
- **Package `result_pipe_pkg`.** Load-size encodings LS_BYTE = 2'd0, LS_HALF = 2'd1, LS_WORD = 2'd2, and the 32-bit data width constant.
- **Sub-module `load_align`.** Combinational; inputs word, size, signed, addr_low; output extended value. Instantiated once in the M→W path.

## Test plan
- **ALU result.** ALU write r5 = 0x1234 at edge 0 → src1 = (1, 5, 0x1234) in cycle 1; src2/wb = (1, 5, 0x1234) in cycle 2; ex_ready stays 1.
- **Signed byte load with delayed response.** lb, signed, addr_low = 3 into r7; response 0x80FF_FF00 three cycles later → src1 = (0, 7) for three cycles; ex_ready low while waiting; wb r7 = 0xFFFF_FF80 the cycle after the response.
- **Unsigned half load.** lhu, addr_low = 2, data 0xBEEF_0000 → wb = 0x0000_BEEF.
- **Flush of pending load, then new load.** Flush a pending load; the next EX load enters; first response 0x1111 dropped, second 0x2222 written → wb_data = 0x2222 only.
- **Write to r0.** Dest r0 ALU op → wb_we = 0 throughout; src1_reg = 0.
- **Perf counter.** With `RESULT_PIPE_PERF_EN`, a 4-cycle load wait → load_wait_cycles = 4. Without the macro → 0.
